// File: rtl/ping_tof_acc.sv
// ping_tof_acc
//   Periodic ping generator and echo time-of-flight accumulator. While running,
//   a phase counter sweeps 0 .. 2^PERIOD_W-1 once per ping. The first and last
//   accepted echo phases of each ping are folded into frame totals (sums,
//   hit/miss counts, min first / max last). After 2^NPING_W pings the totals
//   are published with a one-cycle frame_valid and the next frame starts
//   without a gap.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   start        one-cycle pulse, starts continuous measurement (IDLE only)
//   stop         one-cycle pulse, stop at the end of the current frame
//   echo_stb     one-cycle received-echo strobe
//   ping_stb     high in the phase-0 cycle of every period while running
//   busy         high while running
//   frame_valid  one-cycle pulse, result outputs updated in the same cycle
//   sum_first    sum of first-echo phases over hit pings
//   sum_last     sum of last-echo phases over hit pings
//   hits         pings with at least one accepted echo
//   misses       pings without an accepted echo
//   min_first    smallest first-echo phase of the frame (all ones if no hit)
//   max_last     largest last-echo phase of the frame (0 if no hit)
module ping_tof_acc #(
  parameter int PERIOD_W = 12,
  parameter int NPING_W  = 8,
  parameter int BLANK    = 16,
  parameter int ACC_W    = PERIOD_W + NPING_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                echo_stb,
  output logic                ping_stb,
  output logic                busy,
  output logic                frame_valid,
  output logic [ACC_W-1:0]    sum_first,
  output logic [ACC_W-1:0]    sum_last,
  output logic [NPING_W:0]    hits,
  output logic [NPING_W:0]    misses,
  output logic [PERIOD_W-1:0] min_first,
  output logic [PERIOD_W-1:0] max_last
);

  localparam int CNT_W = NPING_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [PERIOD_W-1:0] phase;
  logic [NPING_W-1:0]  ping_idx;
  logic                stop_pending;
  // One RUN cycle after a stopped frame closes: frame_valid is out, busy is
  // still high, but no new ping is started and echoes are ignored.
  logic                draining;

  // Per-ping capture
  logic                got;
  logic [PERIOD_W-1:0] first_ph;
  logic [PERIOD_W-1:0] last_ph;

  // Frame accumulators
  logic [ACC_W-1:0]    acc_first;
  logic [ACC_W-1:0]    acc_last;
  logic [CNT_W-1:0]    acc_hits;
  logic [CNT_W-1:0]    acc_misses;
  logic [PERIOD_W-1:0] acc_min;
  logic [PERIOD_W-1:0] acc_max;

  // Datapath helpers
  logic                active;
  logic                blank_ok;
  logic                accept;
  logic                ping_end;
  logic                frame_end;
  logic                ping_got;
  logic [PERIOD_W-1:0] ping_first;
  logic [PERIOD_W-1:0] ping_last;
  logic [ACC_W-1:0]    fold_first;
  logic [ACC_W-1:0]    fold_last;
  logic [CNT_W-1:0]    fold_hits;
  logic [CNT_W-1:0]    fold_misses;
  logic [PERIOD_W-1:0] fold_min;
  logic [PERIOD_W-1:0] fold_max;

  // Blanking window; BLANK=0 accepts every phase.
  generate
    if (BLANK == 0) begin : g_noblank
      assign blank_ok = 1'b1;
    end else begin : g_blank
      assign blank_ok = (phase >= PERIOD_W'(BLANK));
    end
  endgenerate

  // FSM next state and control outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ping_stb  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        ping_stb = (phase == '0) && !draining;
        if (draining) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The closing ping's totals include the echo arriving in the close cycle,
  // so the fold works on the captured values merged with this cycle's echo.
  always_comb begin
    active     = (state == S_RUN) && !draining;
    accept     = active && echo_stb && blank_ok;
    ping_end   = active && (phase == '1);
    frame_end  = ping_end && (ping_idx == '1);

    ping_got   = got | accept;
    ping_first = got ? first_ph : phase;
    ping_last  = accept ? phase : last_ph;

    fold_first  = acc_first;
    fold_last   = acc_last;
    fold_hits   = acc_hits;
    fold_misses = acc_misses;
    fold_min    = acc_min;
    fold_max    = acc_max;
    if (ping_got) begin
      fold_first = acc_first + ACC_W'(ping_first);
      fold_last  = acc_last + ACC_W'(ping_last);
      fold_hits  = acc_hits + CNT_W'(1);
      if (ping_first < acc_min) begin
        fold_min = ping_first;
      end
      if (ping_last > acc_max) begin
        fold_max = ping_last;
      end
    end else begin
      fold_misses = acc_misses + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      phase        <= '0;
      ping_idx     <= '0;
      stop_pending <= 1'b0;
      draining     <= 1'b0;
      got          <= 1'b0;
      first_ph     <= '0;
      last_ph      <= '0;
      acc_first    <= '0;
      acc_last     <= '0;
      acc_hits     <= '0;
      acc_misses   <= '0;
      acc_min      <= '1;
      acc_max      <= '0;
      frame_valid  <= 1'b0;
      sum_first    <= '0;
      sum_last     <= '0;
      hits         <= '0;
      misses       <= '0;
      min_first    <= '1;
      max_last     <= '0;
    end else begin
      state       <= state_nxt;
      frame_valid <= 1'b0;

      if (state == S_IDLE) begin
        if (start) begin
          phase        <= '0;
          ping_idx     <= '0;
          stop_pending <= 1'b0;
          draining     <= 1'b0;
          got          <= 1'b0;
          first_ph     <= '0;
          last_ph      <= '0;
          acc_first    <= '0;
          acc_last     <= '0;
          acc_hits     <= '0;
          acc_misses   <= '0;
          acc_min      <= '1;
          acc_max      <= '0;
        end
      end else if (draining) begin
        draining     <= 1'b0;
        stop_pending <= 1'b0;
      end else begin
        phase <= phase + PERIOD_W'(1);
        if (stop) begin
          stop_pending <= 1'b1;
        end

        if (accept) begin
          got     <= 1'b1;
          last_ph <= phase;
          if (!got) begin
            first_ph <= phase;
          end
        end

        // Ping close overrides the capture update above.
        if (ping_end) begin
          got      <= 1'b0;
          first_ph <= '0;
          last_ph  <= '0;
          ping_idx <= ping_idx + NPING_W'(1);

          if (frame_end) begin
            frame_valid <= 1'b1;
            sum_first   <= fold_first;
            sum_last    <= fold_last;
            hits        <= fold_hits;
            misses      <= fold_misses;
            min_first   <= fold_min;
            max_last    <= fold_max;
            acc_first   <= '0;
            acc_last    <= '0;
            acc_hits    <= '0;
            acc_misses  <= '0;
            acc_min     <= '1;
            acc_max     <= '0;
            // A stop arriving in the close cycle still ends this frame.
            if (stop_pending || stop) begin
              draining <= 1'b1;
            end
          end else begin
            acc_first  <= fold_first;
            acc_last   <= fold_last;
            acc_hits   <= fold_hits;
            acc_misses <= fold_misses;
            acc_min    <= fold_min;
            acc_max    <= fold_max;
          end
        end
      end
    end
  end

endmodule

// File: doc/ping_tof_acc.md
Name: ping_tof_acc

Overview:
- Parametrised ping/echo time-of-flight accumulator, successor to the fixed 4096-cycle / 256-ping phase-ping logic.
- Emits a periodic ping strobe to the TX block and timestamps the first and last echo strobes, relative to each ping, from the digitizer/hex_dump receive path.
- Accumulates per-frame sums, hit/miss counts and min/max extremes.
- Presents frame results with a one-cycle valid pulse for UART reporting.

Parameters:
- PERIOD_W, 12: ping period is 2^PERIOD_W cycles; phase counter width.
- NPING_W, 8: 2^NPING_W pings per frame.
- BLANK, 16: echoes at phase < BLANK are ignored (TX feedthrough rejection); 0 disables blanking.
- ACC_W, PERIOD_W+NPING_W: sum width (overflow impossible by construction).

Ports:
- clk  in  1  system clock (48 MHz)
- rst  in  1  synchronous reset, active-low (rst=0 resets)
- start  in  1  one-cycle pulse; begins continuous measurement
- stop  in  1  one-cycle pulse; stop request, honoured at frame boundary
- echo_stb  in  1  one-cycle received-echo strobe
- ping_stb  out  1  high for the phase-0 cycle of every period while running
- busy  out  1  high while in RUN
- frame_valid  out  1  one-cycle pulse; result outputs updated in the same cycle
- sum_first  out  ACC_W  sum of first-echo phases over hit pings
- sum_last  out  ACC_W  sum of last-echo phases over hit pings
- hits  out  NPING_W+1  pings with at least one accepted echo
- misses  out  NPING_W+1  pings with no accepted echo
- min_first  out  PERIOD_W  smallest first-echo phase in frame
- max_last  out  PERIOD_W  largest last-echo phase in frame

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; phase, ping index and all accumulators cleared.
  - Outputs after reset: ping_stb=0, busy=0, frame_valid=0, sums=0, hits=0, misses=0, min_first=all ones, max_last=0.
  - Reset mid-frame discards the partial frame; no frame_valid is produced.
- States:
  - IDLE: start -> RUN (phase=0, ping index=0, per-ping and frame accumulators cleared).
  - RUN: after the frame closes, stop_pending -> IDLE; otherwise stay in RUN.
- Timing: start sampled in cycle T -> busy=1 and ping_stb=1 in T+1. phase=0 in that cycle, increments by 1 every cycle and wraps 2^PERIOD_W-1 -> 0.
- start while busy is ignored. stop while IDLE is ignored.
- stop in RUN sets stop_pending. The current frame completes and frame_valid is emitted; the next cycle has busy=0 and no further ping_stb. start and stop in the same cycle in IDLE: start wins, stop is ignored.
- Echo acceptance: echo_stb in a RUN cycle with phase >= BLANK is accepted, including phase 2^PERIOD_W-1. The echo in the same cycle as ping_stb has phase 0 and is rejected unless BLANK=0.
  - First accepted echo of a ping latches first_ph.
  - Every accepted echo updates last_ph.
  - Any accepted echo sets got.
- Ping close, in the cycle phase=2^PERIOD_W-1, with that cycle's echo included:
  - If got: sum_first+=first_ph, sum_last+=last_ph, hits+=1, min_first=min(min_first,first_ph), max_last=max(max_last,last_ph).
  - Else: misses+=1.
  - got/first/last are cleared for the next ping.
- Frame close: at the close of ping index 2^NPING_W-1, the next cycle has frame_valid=1 and all result outputs loaded with the final frame values.
  - Outputs hold until the next frame_valid or reset.
  - Internal accumulators restart for the next frame with no lost cycle; ping_stb of the next frame coincides with frame_valid.
- Invariant: hits+misses=2^NPING_W at every frame_valid. If hits=0: min_first=all ones, max_last=0, sums=0.
- Sums are unsigned with width exactly ACC_W; hits/misses are NPING_W+1 bits so a full frame of 2^NPING_W fits.

Test Plan (PERIOD_W=4, NPING_W=2, BLANK=4 unless stated; start in cycle 0):
- Reset -> all outputs at reset values; start then rst=0 in cycle 20 -> busy=0, no frame_valid through cycle 200.
- One echo at phase 5 in every ping -> ping_stb at cycles 1,17,33,49; frame_valid at cycle 65 with sum_first=20, sum_last=20, hits=4, misses=0, min_first=5, max_last=5; next ping_stb at cycle 65.
- Echoes at phases 3,7,12 in every ping -> phase 3 blanked; sum_first=28, sum_last=48, min_first=7, max_last=12.
- Echoes only in pings 0 and 2, at phases 15 and 0 of the following period -> phase 15 accepted, phase 0 rejected; hits=2, misses=2, sum_first=30, max_last=15. With BLANK=0 the phase-0 echo is accepted.
- stop at cycle 30 -> frame_valid at 65, busy=0 from 66, no ping_stb after 49; start at 40 while busy is ignored.
- No echoes at all -> hits=0, misses=4, min_first=15, max_last=0, sums=0.
